// File: rtl/ram_mfc_responder_if.sv
// CPU <-> data memory handshake bundle (MOV/MFC request-complete protocol).
interface ram_mfc_responder_if;
  logic        MOV;
  logic        RW;
  logic [1:0]  TYPE;
  logic [31:0] ADDRESS;
  logic [31:0] DATA_IN;
  logic [31:0] DATA_OUT;
  logic        MFC;
  logic        ERR;
  logic        BUSY;

  // CPU control unit side
  modport master (
    output MOV, RW, TYPE, ADDRESS, DATA_IN,
    input  DATA_OUT, MFC, ERR, BUSY
  );

  // Memory responder side
  modport slave (
    input  MOV, RW, TYPE, ADDRESS, DATA_IN,
    output DATA_OUT, MFC, ERR, BUSY
  );
endinterface

// File: rtl/ram_mfc_responder.sv
// Byte-addressable big-endian data memory answering the MOV/MFC handshake
// after a fixed access latency.
module ram_mfc_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  ram_mfc_responder_if.slave bus
);

  localparam int unsigned MEM_BYTES = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic                  rw;
    logic [1:0]            size;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
  } req_t;

  state_t             state, state_nxt;
  req_t               req_q, req_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mfc_d, err_d, busy_d;
  logic [31:0]        dout_d;
  logic [3:0]         we_c;
  logic [7:0]         wb_c [4];
  logic [7:0]         rb_c [4];
  logic [31:0]        rdata_c;
  logic               fault_c;
  logic [7:0]         mem [MEM_BYTES];

  // Upper address bits are deliberately ignored (address wraps).
  wire unused_addr_hi = &{1'b0, bus.ADDRESS[31:ADDR_WIDTH]};

  // Alignment / reserved-size fault decode for the latched request
  always_comb begin
    fault_c = 1'b0;
    case (req_q.size)
      2'b00:   fault_c = 1'b0;
      2'b01:   fault_c = req_q.addr[0];
      2'b10:   fault_c = (req_q.addr[1:0] != 2'b00);
      default: fault_c = 1'b1;
    endcase
  end

  // Big-endian read assembly, zero-extended and right-justified
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rb_c[i] = mem[req_q.addr + ADDR_WIDTH'(i)];
    end
    case (req_q.size)
      2'b00:   rdata_c = {24'd0, rb_c[0]};
      2'b01:   rdata_c = {16'd0, rb_c[0], rb_c[1]};
      2'b10:   rdata_c = {rb_c[0], rb_c[1], rb_c[2], rb_c[3]};
      default: rdata_c = 32'd0;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.MOV)         state_nxt = S_WAIT;
      S_WAIT:  if (cnt_q == '0)     state_nxt = S_DONE;
      S_DONE:  if (!bus.MOV)        state_nxt = S_IDLE;
      default:                      state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values; access is performed on the WAIT->DONE edge
  always_comb begin
    mfc_d  = bus.MFC;
    err_d  = bus.ERR;
    busy_d = bus.BUSY;
    dout_d = bus.DATA_OUT;
    req_d  = req_q;
    cnt_d  = cnt_q;
    we_c   = 4'b0000;
    for (int i = 0; i < 4; i++) wb_c[i] = req_q.wdata[31-8*i -: 8];
    case (req_q.size)
      2'b00:   wb_c[0] = req_q.wdata[7:0];
      2'b01:   begin wb_c[0] = req_q.wdata[15:8]; wb_c[1] = req_q.wdata[7:0]; end
      default: ;
    endcase
    case (state)
      S_IDLE: begin
        if (bus.MOV) begin
          req_d  = '{rw: bus.RW, size: bus.TYPE,
                     addr: bus.ADDRESS[ADDR_WIDTH-1:0], wdata: bus.DATA_IN};
          cnt_d  = CNT_W'(WAIT_CYCLES);
          busy_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          mfc_d = 1'b1;
          err_d = fault_c;
          if (fault_c)       dout_d = 32'd0;
          else if (req_q.rw) dout_d = rdata_c;
          else begin
            case (req_q.size)
              2'b00:   we_c = 4'b0001;
              2'b01:   we_c = 4'b0011;
              2'b10:   we_c = 4'b1111;
              default: we_c = 4'b0000;
            endcase
          end
        end
      end
      S_DONE: begin
        if (!bus.MOV) begin
          mfc_d  = 1'b0;
          err_d  = 1'b0;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, latched request and latency counter
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bus.MFC      <= 1'b0;
      bus.ERR      <= 1'b0;
      bus.BUSY     <= 1'b0;
      bus.DATA_OUT <= 32'd0;
      req_q        <= '0;
      cnt_q        <= '0;
    end else begin
      bus.MFC      <= mfc_d;
      bus.ERR      <= err_d;
      bus.BUSY     <= busy_d;
      bus.DATA_OUT <= dout_d;
      req_q        <= req_d;
      cnt_q        <= cnt_d;
    end
  end

  // Byte-lane memory writes; contents survive reset
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (we_c[i]) mem[req_q.addr + ADDR_WIDTH'(i)] <= wb_c[i];
    end
  end

endmodule

// File: tb/tb_ram_mfc_responder.sv
// Directed bench for ram_mfc_responder: vector table plus handshake corner cases.
module tb_ram_mfc_responder;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  ram_mfc_responder_if bus0 ();
  ram_mfc_responder_if bus1 ();

  logic        mov_s  [2];
  logic        rw_s   [2];
  logic [1:0]  typ_s  [2];
  logic [31:0] addr_s [2];
  logic [31:0] din_s  [2];
  logic        mfc_w  [2];
  logic        err_w  [2];
  logic        busy_w [2];
  logic [31:0] dout_w [2];

  assign bus0.MOV = mov_s[0];  assign bus1.MOV = mov_s[1];
  assign bus0.RW  = rw_s[0];   assign bus1.RW  = rw_s[1];
  assign bus0.TYPE = typ_s[0]; assign bus1.TYPE = typ_s[1];
  assign bus0.ADDRESS = addr_s[0]; assign bus1.ADDRESS = addr_s[1];
  assign bus0.DATA_IN = din_s[0];  assign bus1.DATA_IN = din_s[1];
  assign mfc_w[0] = bus0.MFC;  assign mfc_w[1] = bus1.MFC;
  assign err_w[0] = bus0.ERR;  assign err_w[1] = bus1.ERR;
  assign busy_w[0] = bus0.BUSY; assign busy_w[1] = bus1.BUSY;
  assign dout_w[0] = bus0.DATA_OUT; assign dout_w[1] = bus1.DATA_OUT;

  ram_mfc_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut0 (
    .CLK(CLK), .RESET(RESET), .bus(bus0));
  ram_mfc_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut1 (
    .CLK(CLK), .RESET(RESET), .bus(bus1));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw;
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        err;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full request/complete handshake; inputs are scrambled after acceptance.
  task automatic txn(input int sel, input logic rw, input logic [1:0] typ,
                     input logic [31:0] addr, input logic [31:0] din,
                     input logic [31:0] exp_dout, input logic exp_err,
                     input int exp_lat, input int hold, input string name);
    int   n;
    logic got;
    @(negedge CLK);
    mov_s[sel] = 1'b1; rw_s[sel] = rw; typ_s[sel] = typ;
    addr_s[sel] = addr; din_s[sel] = din;
    @(posedge CLK); #1;
    chk({name, " busy"}, 32'(busy_w[sel]), 32'd1);
    rw_s[sel] = ~rw; typ_s[sel] = typ ^ 2'b01;
    addr_s[sel] = addr ^ 32'h4; din_s[sel] = ~din;
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      @(posedge CLK); #1;
      n++;
      got = mfc_w[sel];
    end
    chk({name, " latency"}, 32'(n), 32'(exp_lat));
    chk({name, " err"}, 32'(err_w[sel]), 32'(exp_err));
    chk({name, " dout"}, dout_w[sel], exp_dout);
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK); #1;
      chk({name, " hold mfc"}, 32'(mfc_w[sel]), 32'd1);
      chk({name, " hold dout"}, dout_w[sel], exp_dout);
    end
    @(negedge CLK);
    mov_s[sel] = 1'b0;
    @(posedge CLK); #1;
    chk({name, " exit mfc"}, 32'(mfc_w[sel]), 32'd0);
    chk({name, " exit busy"}, 32'(busy_w[sel]), 32'd0);
    chk({name, " exit err"}, 32'(err_w[sel]), 32'd0);
    chk({name, " exit dout"}, dout_w[sel], exp_dout);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic seen;

    vecs[0]  = '{1'b0, 2'b10, 32'h10,       32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 2'b10, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'b00, 32'h11,       32'h0,        32'h000000AD, 1'b0};
    vecs[3]  = '{1'b1, 2'b01, 32'h12,       32'h0,        32'h0000BEEF, 1'b0};
    vecs[4]  = '{1'b0, 2'b00, 32'h13,       32'h55,       32'h0000BEEF, 1'b0};
    vecs[5]  = '{1'b1, 2'b10, 32'h10,       32'h0,        32'hDEADBE55, 1'b0};
    vecs[6]  = '{1'b1, 2'b10, 32'h22,       32'h0,        32'h00000000, 1'b1};
    vecs[7]  = '{1'b0, 2'b01, 32'h11,       32'h1234,     32'h00000000, 1'b1};
    vecs[8]  = '{1'b1, 2'b10, 32'h10,       32'h0,        32'hDEADBE55, 1'b0};
    vecs[9]  = '{1'b0, 2'b10, 32'h40,       32'hCAFEF00D, 32'hDEADBE55, 1'b0};
    vecs[10] = '{1'b1, 2'b10, 32'h140,      32'h0,        32'hCAFEF00D, 1'b0};
    vecs[11] = '{1'b1, 2'b11, 32'h10,       32'h0,        32'h00000000, 1'b1};
    vecs[12] = '{1'b0, 2'b01, 32'hFFFFFF20, 32'hA5A5,     32'h00000000, 1'b0};
    vecs[13] = '{1'b1, 2'b00, 32'h21,       32'h0,        32'h000000A5, 1'b0};
    vecs[14] = '{1'b1, 2'b01, 32'h20,       32'h0,        32'h0000A5A5, 1'b0};

    for (int s = 0; s < 2; s++) begin
      mov_s[s] = 1'b0; rw_s[s] = 1'b0; typ_s[s] = 2'b00;
      addr_s[s] = 32'd0; din_s[s] = 32'd0;
    end

    // Reset state
    RESET = 1'b1;
    #12;
    chk("reset mfc",  32'(mfc_w[0]),  32'd0);
    chk("reset err",  32'(err_w[0]),  32'd0);
    chk("reset busy", 32'(busy_w[0]), 32'd0);
    chk("reset dout", dout_w[0],      32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // Table of transactions against the WAIT_CYCLES=2 instance
    for (int i = 0; i < 15; i++) begin
      txn(0, vecs[i].rw, vecs[i].typ, vecs[i].addr, vecs[i].din,
          vecs[i].dout, vecs[i].err, 3, 0, $sformatf("vec%0d", i));
    end

    // MOV held in DONE keeps MFC high
    txn(0, 1'b1, 2'b10, 32'h10, 32'h0, 32'hDEADBE55, 1'b0, 3, 5, "hold5");

    // MOV dropped during WAIT: transaction completes, MFC pulses one cycle
    @(negedge CLK);
    mov_s[0] = 1'b1; rw_s[0] = 1'b1; typ_s[0] = 2'b10; addr_s[0] = 32'h140;
    @(posedge CLK);
    @(negedge CLK);
    mov_s[0] = 1'b0;
    n = 0; seen = 1'b0;
    while (n < 20 && !seen) begin
      @(posedge CLK); #1;
      n++;
      seen = mfc_w[0];
    end
    chk("drop latency", 32'(n), 32'd3);
    chk("drop dout", dout_w[0], 32'hCAFEF00D);
    @(posedge CLK); #1;
    chk("drop pulse mfc", 32'(mfc_w[0]), 32'd0);
    chk("drop busy", 32'(busy_w[0]), 32'd0);

    // Reset during WAIT discards the pending write
    @(negedge CLK);
    mov_s[0] = 1'b1; rw_s[0] = 1'b0; typ_s[0] = 2'b10;
    addr_s[0] = 32'h40; din_s[0] = 32'h12345678;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    chk("rstwait busy", 32'(busy_w[0]), 32'd0);
    chk("rstwait dout", dout_w[0], 32'd0);
    mov_s[0] = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      if (mfc_w[0]) seen = 1'b1;
    end
    chk("rstwait no mfc", 32'(seen), 32'd0);
    txn(0, 1'b1, 2'b10, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 3, 0, "rstwait read");

    // Reset in DONE drops MFC asynchronously
    @(negedge CLK);
    mov_s[0] = 1'b1; rw_s[0] = 1'b1; typ_s[0] = 2'b00; addr_s[0] = 32'h10;
    n = 0; seen = 1'b0;
    while (n < 20 && !seen) begin
      @(posedge CLK); #1;
      n++;
      seen = mfc_w[0];
    end
    chk("rstdone mfc before", 32'(mfc_w[0]), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    chk("rstdone mfc async", 32'(mfc_w[0]), 32'd0);
    mov_s[0] = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;

    // Zero-latency instance, back-to-back requests
    txn(1, 1'b0, 2'b10, 32'h08, 32'h01020304, 32'h00000000, 1'b0, 1, 0, "wc0 write");
    txn(1, 1'b1, 2'b00, 32'h0B, 32'h0,        32'h00000004, 1'b0, 1, 0, "wc0 rbyte");
    txn(1, 1'b1, 2'b10, 32'h08, 32'h0,        32'h01020304, 1'b0, 1, 0, "wc0 rword");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
